wbuf_drain: RTL

Write-buffer drain engine: the read-side consumer of the store FIFO. Pops queued stores `{addr, strb, data}` from the FIFO's empty/read/outdata interface. Issues them one at a time on a single-outstanding write request channel toward the data bus. Reports when the buffer is fully drained, which SYNC and uncached loads use for ordering.

---
 rtl/wbuf_drain.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wbuf_drain.sv
// wbuf_drain: read-side consumer of the store FIFO.
//
// This block pops queued stores {addr, strb, data} from the FIFO and
// issues them one at a time on a write request channel. Only one write
// may be outstanding at a time. The idle output tells SYNC and uncached
// loads when the buffer is fully drained.
//
// Optional feature: `WBUF_DRAIN_MERGE_EN
//   When defined, the COLLECT state and the merge counter are compiled in.
//   Consecutive stores to the same word are coalesced into one write, up
//   to MERGE_MAX entries. When undefined, each FIFO entry becomes exactly
//   one write.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   drain_en      allows new entries to be popped; never aborts an in-flight write
//   fifo_empty    FIFO empty flag
//   fifo_data     FIFO head {addr[ADDR_W-1:0], strb[3:0], data[31:0]}
//   fifo_read     pop strobe; the FIFO advances on the same edge
//   wr_req        write request valid (state REQ)
//   wr_addr       word-aligned write address
//   wr_data       write data
//   wr_strb       byte enables
//   wr_ack        request accepted; only looked at in REQ
//   wr_done       write response; only looked at in RESP
//   idle          fifo_empty & state==IDLE
module wbuf_drain #(
  parameter int ADDR_W    = 32,
  parameter int MERGE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [ADDR_W+35:0] fifo_data,
  output logic              fifo_read,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_ack,
  input  logic              wr_done,
  output logic              idle
);

  localparam logic [3:0] MMAX = 4'(MERGE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2
`ifdef WBUF_DRAIN_MERGE_EN
    ,
    COLLECT = 2'd3
`endif
  } state_t;

  // State entered after a fresh capture.
`ifdef WBUF_DRAIN_MERGE_EN
  localparam state_t FILL = COLLECT;
`else
  localparam state_t FILL = REQ;
`endif

  // Split the FIFO head into fields. Only the word address matters here,
  // because the bus address is always word aligned.
  logic [ADDR_W-3:0] head_word;
  logic [3:0]        head_strb;
  logic [31:0]       head_data;
  assign head_word = fifo_data[ADDR_W+35:38];
  assign head_strb = fifo_data[35:32];
  assign head_data = fifo_data[31:0];

  state_t            state, state_nxt;
  logic [ADDR_W-3:0] h_word;
  logic [31:0]       h_data;
  logic [3:0]        h_strb;
  logic              can_pop;
  logic              load;    // fresh capture into an empty holding register
  logic              merge;   // fold the head into the held entry
  logic              merge_ok;

  assign can_pop = drain_en & ~fifo_empty;

`ifdef WBUF_DRAIN_MERGE_EN
  logic [3:0]  cnt;
  logic [31:0] mrg_data;

  assign merge_ok = can_pop & (head_word == h_word) & (cnt < MMAX);

  // Byte-wise overlay: a newer store wins on every byte it enables.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign mrg_data[8*i +: 8] = head_strb[i] ? head_data[8*i +: 8] : h_data[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset)      cnt <= 4'd0;
    else if (load)  cnt <= 4'd1;
    else if (merge) cnt <= cnt + 4'd1;
  end

  logic unused_bits;
  assign unused_bits = ^fifo_data[37:36];
`else
  assign merge_ok = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{fifo_data[37:36], MMAX, merge_ok};
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    merge     = 1'b0;
    case (state)
      IDLE: begin
        if (can_pop) begin
          load      = 1'b1;
          state_nxt = FILL;
        end
      end
`ifdef WBUF_DRAIN_MERGE_EN
      COLLECT: begin
        if (merge_ok) merge     = 1'b1;
        else          state_nxt = REQ;
      end
`endif
      REQ: begin
        if (wr_ack) state_nxt = RESP;
      end
      RESP: begin
        // When the response arrives, pop the next entry in the same cycle
        // so back-to-back writes do not pass through IDLE.
        if (wr_done) begin
          if (can_pop) begin
            load      = 1'b1;
            state_nxt = FILL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      h_word <= '0;
      h_data <= '0;
      h_strb <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        h_word <= head_word;
        h_data <= head_data;
        h_strb <= head_strb;
      end
`ifdef WBUF_DRAIN_MERGE_EN
      else if (merge) begin
        h_data <= mrg_data;
        h_strb <= h_strb | head_strb;
      end
`endif
    end
  end

  // Suppress the pop while reset is asserted. Otherwise the FIFO could
  // advance while the state register is being cleared.
  assign fifo_read = (load | merge) & ~reset;
  assign wr_req    = (state == REQ);
  assign wr_addr   = {h_word, 2'b00};
  assign wr_data   = h_data;
  assign wr_strb   = h_strb;
  assign idle      = fifo_empty & (state == IDLE);

endmodule
